// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional last-result cache enabled by defining DIV_CACHE_EN.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             op_rem;
  logic             q_neg;
  logic             r_neg;

  // Operand decode for the IDLE launch decision.
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;

  assign is_signed = ~Op[0];
  assign a_neg     = is_signed & A[WIDTH-1];
  assign b_neg     = is_signed & B[WIDTH-1];
  assign a_abs     = a_neg ? -A : A;
  assign b_abs     = b_neg ? -B : B;
  assign b_zero    = (B == '0);
  assign ovf       = is_signed & (A == MIN_INT) & (B == '1);
  assign special   = b_zero | ovf;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    special_res = '0;
    if (b_zero)
      special_res = Op[1] ? A : '1;
    else if (ovf)
      special_res = Op[1] ? '0 : A;
  end

  // One restoring step: the trial remainder needs WIDTH+1 bits to hold 2*rem+1.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] calc_res;

  assign trial    = {rem, quo[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs};
  assign fits     = ~diff[WIDTH];
  assign rem_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], fits};
  assign quo_fix  = q_neg ? -quo_step : quo_step;
  assign rem_fix  = r_neg ? -rem_step : rem_step;
  assign calc_res = op_rem ? rem_fix : quo_fix;

  logic             hit;
  logic [WIDTH-1:0] cache_res;

`ifdef DIV_CACHE_EN
  logic             cache_valid;
  logic [WIDTH-1:0] cache_a;
  logic [WIDTH-1:0] cache_b;
  logic             cache_signed;
  logic [WIDTH-1:0] cache_quo;
  logic [WIDTH-1:0] cache_rem;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;
  logic             pend_signed;
  logic             launch;
  logic             finish;

  assign hit       = cache_valid & (A == cache_a) & (B == cache_b) & (is_signed == cache_signed);
  assign cache_res = Op[1] ? cache_rem : cache_quo;
  assign launch    = (state == S_IDLE) & Start & ~Flush & ~special & ~hit;
  assign finish    = (state == S_CALC) & (cnt == '0) & ~Flush;

  // NOTE: the cache is a handful of flops, not a RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_signed <= 1'b0;
      cache_quo    <= '0;
      cache_rem    <= '0;
      pend_a       <= '0;
      pend_b       <= '0;
      pend_signed  <= 1'b0;
    end else begin
      if (launch) begin
        pend_a      <= A;
        pend_b      <= B;
        pend_signed <= is_signed;
      end
      // Only a completed, unflushed iterative op is remembered.
      if (finish) begin
        cache_valid  <= 1'b1;
        cache_a      <= pend_a;
        cache_b      <= pend_b;
        cache_signed <= pend_signed;
        cache_quo    <= quo_fix;
        cache_rem    <= rem_fix;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign cache_res = '0;
`endif

  assign Stall = Start & ~Done & ~Flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      op_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
    end else begin
      Done <= 1'b0;
      if (Flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (Start) begin
              if (special) begin
                Result <= special_res;
                Done   <= 1'b1;
                state  <= S_DONE;
              end else if (hit) begin
                Result <= cache_res;
                Done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                op_rem <= Op[1];
                q_neg  <= a_neg ^ b_neg;
                r_neg  <= a_neg;
                quo    <= a_abs;
                rem    <= '0;
                dvs    <= b_abs;
                cnt    <= CW'(WIDTH - 1);
                state  <= S_CALC;
              end
            end
          end
          S_CALC: begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              Result <= calc_res;
              Done   <= 1'b1;
              state  <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: table of divide vectors plus flush, cache and reset sequences.
module tb_iter_divider;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Stall;
  logic        Done;
  logic [31:0] Result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 33;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  iter_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Flush  (Flush),
    .Stall  (Stall),
    .Done   (Done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered just after a posedge; returns just after the posedge that ends the Done cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int  lat;
    int  stalls;
    bit  seen;
    Start  = 1'b1;
    Op     = op;
    A      = a;
    B      = b;
    lat    = 0;
    stalls = 0;
    seen   = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (Stall) stalls++;
      if (Done) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
      check({name, " result"}, Result, exp_res);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done_seen;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[2]  = '{OP_REMU, 32'd7,          32'd2,          32'd1,          33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[10] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[11] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[12] = '{OP_REMU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  33};
    vecs[13] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33};
    vecs[14] = '{OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  33};

    rst_n = 1'b0;
    Start = 1'b0;
    Op    = 2'b00;
    A     = '0;
    B     = '0;
    Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset done", 32'(Done), 32'd0);
    check("reset result", Result, 32'd0);
    check("reset stall", 32'(Stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table ops issued back to back: Start stays high into the IDLE cycle after each Done.
    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    Start = 1'b0;
    @(negedge clk);
    check("done_single_pulse", 32'(Done), 32'd0);
    check("idle stall", 32'(Stall), 32'd0);
    @(posedge clk);
    #1;

    // Flush in cycle 10 of DIVU 1000/3.
    Start = 1'b1;
    Op    = OP_DIVU;
    A     = 32'd1000;
    B     = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(negedge clk);
    check("flush stall", 32'(Stall), 32'd0);
    @(posedge clk);
    #1;
    Flush = 1'b0;
    Start = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done) done_seen = 1'b1;
    end
    check("flush no_done", 32'(done_seen), 32'd0);
    check("flush result_held", Result, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    run_op("after_flush divu", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    // DIV then REM on the same operands; REM is a cache hit when the cache is built in.
    run_op("pair div", OP_DIV, 32'd1000, 32'd3, 32'd333, 33);
    run_op("pair rem", OP_REM, 32'd1000, 32'd3, 32'd1, HIT_LAT);

    // Asynchronous reset in the middle of a calculation.
    Start = 1'b1;
    Op    = OP_DIVU;
    A     = 32'd100;
    B     = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset done", 32'(Done), 32'd0);
    check("midreset result", Result, 32'd0);
    Start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("after_reset divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
